decl_check: RTL

- Streaming checker for C-style scalar declarations, one 8-bit ASCII character per enabled cycle.
- Generalises the single-keyword `int` checker in four ways:
  - accepts type keywords `int` and `char`;
  - enforces a parametrised identifier length limit;
  - counts declared identifiers per statement;
  - resynchronises on `;` after an error instead of dropping back to idle.
- Sits on the character stream of the text-processing datapath; reports a verdict once per statement.

---
 rtl/decl_check.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/decl_check.sv
// decl_check: streaming checker for C-style scalar declarations of the form
// "int a, b;" or "char x;". One ASCII character is consumed per enabled
// clock. A verdict pulse is produced one cycle after each ';'.
module decl_check #(
    parameter int MAX_ID_LEN = 31,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [7:0]       in,
    output logic             done,
    output logic             ok,
    output logic [CNT_W-1:0] id_count,
    output logic [CNT_W-1:0] stmt_total
);

    // The length tracker must reach MAX_ID_LEN+1 in identifiers and 4 in "char".
    localparam int LEN_MAX = MAX_ID_LEN + 1;
    localparam int LEN_W   = $clog2(((LEN_MAX > 4) ? LEN_MAX : 4) + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TYPE,
        S_TSP,
        S_ID,
        S_IDSP,
        S_SEP,
        S_SKIP
    } state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] len, len_n;
    logic             int_m, int_m_n;
    logic             char_m, char_m_n;
    logic [CNT_W-1:0] id_cnt, id_cnt_n, id_cnt_inc;
    logic [CNT_W-1:0] total_n, total_inc, idc_n;
    logic             done_n, ok_n, err;
    logic             is_sp, is_comma, is_semi, is_alpha, is_digit;
    logic             int_next, char_next, is_kw, id_valid;

    // Character of "int" expected at a given position.
    function automatic logic [7:0] int_char(input logic [LEN_W-1:0] idx);
        logic [7:0] c;
        c = 8'h00;
        if (idx == LEN_W'(0))      c = 8'h69;
        else if (idx == LEN_W'(1)) c = 8'h6E;
        else if (idx == LEN_W'(2)) c = 8'h74;
        return c;
    endfunction

    // Character of "char" expected at a given position.
    function automatic logic [7:0] char_char(input logic [LEN_W-1:0] idx);
        logic [7:0] c;
        c = 8'h00;
        if (idx == LEN_W'(0))      c = 8'h63;
        else if (idx == LEN_W'(1)) c = 8'h68;
        else if (idx == LEN_W'(2)) c = 8'h61;
        else if (idx == LEN_W'(3)) c = 8'h72;
        return c;
    endfunction

    assign is_sp    = (in == 8'h20);
    assign is_comma = (in == 8'h2C);
    assign is_semi  = (in == 8'h3B);
    assign is_alpha = ((in >= 8'h41) && (in <= 8'h5A)) ||
                      ((in >= 8'h61) && (in <= 8'h7A)) || (in == 8'h5F);
    assign is_digit = (in >= 8'h30) && (in <= 8'h39);

    // Keyword match progress: the word so far is still a prefix of "int"/"char".
    assign int_next  = int_m  && (len < LEN_W'(3)) && (in == int_char(len));
    assign char_next = char_m && (len < LEN_W'(4)) && (in == char_char(len));
    assign is_kw     = (int_m && (len == LEN_W'(3))) || (char_m && (len == LEN_W'(4)));
    assign id_valid  = (len <= LEN_W'(MAX_ID_LEN)) && !is_kw;

    assign id_cnt_inc = (id_cnt == '1) ? id_cnt : id_cnt + 1'b1;
    assign total_inc  = (stmt_total == '1) ? stmt_total : stmt_total + 1'b1;

    // Next-state, tracker updates and the registered verdict for the current character.
    always_comb begin
        state_n  = state;
        len_n    = len;
        int_m_n  = int_m;
        char_m_n = char_m;
        id_cnt_n = id_cnt;
        done_n   = 1'b0;
        ok_n     = 1'b0;
        idc_n    = '0;
        total_n  = stmt_total;
        err      = 1'b0;
        if (en) begin
            case (state)
                S_IDLE: begin
                    if (!is_sp) begin
                        if ((in == 8'h69) || (in == 8'h63)) begin
                            state_n  = S_TYPE;
                            len_n    = LEN_W'(1);
                            int_m_n  = (in == 8'h69);
                            char_m_n = (in == 8'h63);
                        end else begin
                            err = 1'b1;
                        end
                    end
                end
                S_TYPE: begin
                    if (int_next || char_next) begin
                        len_n    = len + 1'b1;
                        int_m_n  = int_next;
                        char_m_n = char_next;
                    end else if (is_sp && is_kw) begin
                        state_n = S_TSP;
                    end else begin
                        err = 1'b1;
                    end
                end
                S_TSP, S_SEP: begin
                    if (is_alpha) begin
                        state_n  = S_ID;
                        len_n    = LEN_W'(1);
                        int_m_n  = (in == 8'h69);
                        char_m_n = (in == 8'h63);
                    end else if (!is_sp) begin
                        err = 1'b1;
                    end
                end
                S_ID: begin
                    if (is_alpha || is_digit) begin
                        if (len != LEN_W'(LEN_MAX)) len_n = len + 1'b1;
                        int_m_n  = int_next;
                        char_m_n = char_next;
                    end else if ((is_sp || is_comma || is_semi) && id_valid) begin
                        id_cnt_n = id_cnt_inc;
                        if (is_sp) begin
                            state_n = S_IDSP;
                        end else if (is_comma) begin
                            state_n = S_SEP;
                        end else begin
                            done_n   = 1'b1;
                            ok_n     = 1'b1;
                            idc_n    = id_cnt_inc;
                            total_n  = total_inc;
                            state_n  = S_IDLE;
                            id_cnt_n = '0;
                        end
                    end else begin
                        err = 1'b1;
                    end
                end
                S_IDSP: begin
                    if (is_comma) begin
                        state_n = S_SEP;
                    end else if (is_semi) begin
                        done_n   = 1'b1;
                        ok_n     = 1'b1;
                        idc_n    = id_cnt;
                        total_n  = total_inc;
                        state_n  = S_IDLE;
                        id_cnt_n = '0;
                    end else if (!is_sp) begin
                        err = 1'b1;
                    end
                end
                S_SKIP: begin
                    if (is_semi) begin
                        done_n   = 1'b1;
                        state_n  = S_IDLE;
                        id_cnt_n = '0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
            if (err) begin
                id_cnt_n = '0;
                if (is_semi) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    state_n = S_SKIP;
                end
            end
        end
    end

    // State, trackers and outputs; the verdict outputs fall back to 0 on the edge after done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            len        <= '0;
            int_m      <= 1'b0;
            char_m     <= 1'b0;
            id_cnt     <= '0;
            done       <= 1'b0;
            ok         <= 1'b0;
            id_count   <= '0;
            stmt_total <= '0;
        end else begin
            state      <= state_n;
            len        <= len_n;
            int_m      <= int_m_n;
            char_m     <= char_m_n;
            id_cnt     <= id_cnt_n;
            done       <= done_n;
            ok         <= ok_n;
            id_count   <= idc_n;
            stmt_total <= total_n;
        end
    end

endmodule
